// File: rtl/frame_compositor_if.sv
// Pixel-side bus of the frame compositor: coordinate requests out, layer colours back,
// composited pixel, sync/blank and the per-frame collision report.
interface frame_compositor_if;
   logic [7:0]  player_color;
   logic [7:0]  car_color;
   logic [7:0]  finish_color;
   logic [7:0]  background_color;
   logic [0:10] requested_x;
   logic [0:10] requested_y;
   logic        frame_start;
   logic [0:1]  collisions;
   logic [7:0]  pixel_color;
   logic        hsync;
   logic        vsync;
   logic        blank;

   modport master (
      input  player_color, car_color, finish_color, background_color,
      output requested_x, requested_y, frame_start, collisions,
      output pixel_color, hsync, vsync, blank
   );

   modport slave (
      output player_color, car_color, finish_color, background_color,
      input  requested_x, requested_y, frame_start, collisions,
      input  pixel_color, hsync, vsync, blank
   );
endinterface

// File: rtl/frame_compositor.sv
// VGA raster generator and layer compositor: issues pixel requests, priority-mixes the
// registered layer answers, and reports per-frame player overlaps with a frame_start pulse.
module frame_compositor #(
   parameter int         H_ACTIVE     = 640,
   parameter int         H_TOTAL      = 800,
   parameter int         H_SYNC_START = 656,
   parameter int         H_SYNC_END   = 752,
   parameter int         V_ACTIVE     = 480,
   parameter int         V_TOTAL      = 525,
   parameter int         V_SYNC_START = 490,
   parameter int         V_SYNC_END   = 492,
   parameter logic [7:0] MASK_VALUE   = 8'h62
) (
   input logic               clk,
   input logic               resetN,
   frame_compositor_if.master bus
);

   localparam int CW = 11;
   localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
   localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
   localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
   localparam logic [CW-1:0] H_SS   = CW'(H_SYNC_START);
   localparam logic [CW-1:0] H_SE   = CW'(H_SYNC_END);
   localparam logic [CW-1:0] V_SS   = CW'(V_SYNC_START);
   localparam logic [CW-1:0] V_SE   = CW'(V_SYNC_END);

   localparam logic [1:0] ST_ACTIVE = 2'd0;
   localparam logic [1:0] ST_LATCH  = 2'd1;
   localparam logic [1:0] ST_PULSE  = 2'd2;
   localparam logic [1:0] ST_WAIT   = 2'd3;

   logic [CW-1:0] h_cnt_p0, v_cnt_p0;
   logic          act_p0, hs_p0, vs_p0;
   logic          vld_p1, hs_p1, vs_p1;
   logic [7:0]    pix_p2;
   logic          blank_p2, hs_p2, vs_p2;
   logic [1:0]    state;
   logic [0:1]    acc, coll;

   function automatic logic [7:0] prio_mix(input logic [7:0] p, input logic [7:0] c,
                                           input logic [7:0] f, input logic [7:0] b);
      if (p != MASK_VALUE)      return p;
      else if (c != MASK_VALUE) return c;
      else if (f != MASK_VALUE) return f;
      else if (b != MASK_VALUE) return b;
      else                      return 8'h00;
   endfunction

   // Bit 0: player over car, bit 1: player over finish line.
   function automatic logic [0:1] overlap(input logic [7:0] p, input logic [7:0] c,
                                          input logic [7:0] f);
      return {(p != MASK_VALUE) && (c != MASK_VALUE), (p != MASK_VALUE) && (f != MASK_VALUE)};
   endfunction

   // Stage 0: raster counters double as the outgoing coordinate registers
   assign act_p0 = (h_cnt_p0 < H_ACT) && (v_cnt_p0 < V_ACT);
   assign hs_p0  = !((h_cnt_p0 >= H_SS) && (h_cnt_p0 < H_SE));
   assign vs_p0  = !((v_cnt_p0 >= V_SS) && (v_cnt_p0 < V_SE));

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         h_cnt_p0 <= '0;
         v_cnt_p0 <= '0;
      end else if (h_cnt_p0 == H_LAST) begin
         h_cnt_p0 <= '0;
         v_cnt_p0 <= (v_cnt_p0 == V_LAST) ? '0 : v_cnt_p0 + CW'(1);
      end else begin
         h_cnt_p0 <= h_cnt_p0 + CW'(1);
      end
   end

   // Stage 1: layer colours arrive; flags delayed to match
   // Stage 2: composited pixel and syncs registered together
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         vld_p1   <= 1'b0;
         hs_p1    <= 1'b1;
         vs_p1    <= 1'b1;
         pix_p2   <= 8'h00;
         blank_p2 <= 1'b1;
         hs_p2    <= 1'b1;
         vs_p2    <= 1'b1;
      end else begin
         vld_p1   <= act_p0;
         hs_p1    <= hs_p0;
         vs_p1    <= vs_p0;
         pix_p2   <= vld_p1 ? prio_mix(bus.player_color, bus.car_color, bus.finish_color,
                                       bus.background_color) : 8'h00;
         blank_p2 <= !vld_p1;
         hs_p2    <= hs_p1;
         vs_p2    <= vs_p1;
      end
   end

   // LATCH occupies the cycle whose stage-1 pixel is (0, V_ACTIVE), so the report is
   // stable by the time PULSE raises frame_start.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state <= ST_ACTIVE;
         acc   <= '0;
         coll  <= '0;
      end else begin
         case (state)
            ST_ACTIVE: if (h_cnt_p0 == '0 && v_cnt_p0 == V_ACT) state <= ST_LATCH;
            ST_LATCH:  state <= ST_PULSE;
            ST_PULSE:  state <= ST_WAIT;
            default:   if (v_cnt_p0 == '0) state <= ST_ACTIVE;
         endcase
         if (state == ST_LATCH) begin
            coll <= acc;
            acc  <= '0;
         end else if (vld_p1) begin
            acc  <= acc | overlap(bus.player_color, bus.car_color, bus.finish_color);
         end
      end
   end

   assign bus.requested_x = h_cnt_p0;
   assign bus.requested_y = v_cnt_p0;
   assign bus.frame_start = (state == ST_PULSE);
   assign bus.collisions  = coll;
   assign bus.pixel_color = pix_p2;
   assign bus.hsync       = hs_p2;
   assign bus.vsync       = vs_p2;
   assign bus.blank       = blank_p2;

endmodule

// File: tb/tb_frame_compositor.sv
// Bench for frame_compositor on a reduced raster; layer controllers are modelled as
// registered lookups into per-layer scene images.
module tb_frame_compositor;
   localparam int HA = 16, HT = 24, HSS = 18, HSE = 21;
   localparam int VA = 10, VT = 14, VSS = 11, VSE = 12;
   localparam int FT = HT * VT;
   localparam int FS_K = VA * HT + 2;
   localparam logic [7:0] MASK = 8'h62;

   logic clk, resetN;
   frame_compositor_if ifc ();

   frame_compositor #(
      .H_ACTIVE(HA), .H_TOTAL(HT), .H_SYNC_START(HSS), .H_SYNC_END(HSE),
      .V_ACTIVE(VA), .V_TOTAL(VT), .V_SYNC_START(VSS), .V_SYNC_END(VSE),
      .MASK_VALUE(MASK)
   ) dut (
      .clk(clk), .resetN(resetN), .bus(ifc)
   );

   logic [7:0] scene [4][VT][HT];
   logic [7:0] lc [4];
   bit one_shot;
   int k;
   int n_chk, n_fail;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign ifc.player_color     = lc[0];
   assign ifc.car_color        = lc[1];
   assign ifc.finish_color     = lc[2];
   assign ifc.background_color = lc[3];

   // ---------------- reference model ----------------
   function automatic int px(int kk); return kk % HT; endfunction
   function automatic int py(int kk); return (kk / HT) % VT; endfunction
   function automatic int fr(int kk); return kk / FT; endfunction

   function automatic logic [7:0] lay(int l, int x, int y, int f);
      if (x < 0 || x >= HT || y < 0 || y >= VT) return MASK;
      if (one_shot && f > 0) return MASK;
      return scene[l][y][x];
   endfunction

   function automatic logic is_act(int x, int y);
      return (x < HA) && (y < VA);
   endfunction

   function automatic logic [7:0] exp_pix(int kk);
      int q;
      if (kk < 2) return 8'h00;
      q = kk - 2;
      if (!is_act(px(q), py(q))) return 8'h00;
      for (int l = 0; l < 4; l++)
         if (lay(l, px(q), py(q), fr(q)) != MASK) return lay(l, px(q), py(q), fr(q));
      return 8'h00;
   endfunction

   function automatic logic exp_blank(int kk);
      if (kk < 2) return 1'b1;
      return !is_act(px(kk - 2), py(kk - 2));
   endfunction

   function automatic logic exp_hs(int kk);
      if (kk < 2) return 1'b1;
      return !(px(kk - 2) >= HSS && px(kk - 2) < HSE);
   endfunction

   function automatic logic exp_vs(int kk);
      if (kk < 2) return 1'b1;
      return !(py(kk - 2) >= VSS && py(kk - 2) < VSE);
   endfunction

   function automatic logic exp_fs(int kk);
      return (kk > 0) && (kk % FT == FS_K);
   endfunction

   function automatic logic [0:1] ovl(int f);
      logic [0:1] r;
      r = 2'b00;
      for (int y = 0; y < VA; y++)
         for (int x = 0; x < HA; x++) begin
            if (lay(0, x, y, f) != MASK && lay(1, x, y, f) != MASK) r[0] = 1'b1;
            if (lay(0, x, y, f) != MASK && lay(2, x, y, f) != MASK) r[1] = 1'b1;
         end
      return r;
   endfunction

   function automatic logic [0:1] exp_coll(int kk);
      if (kk < FS_K) return 2'b00;
      return ovl((kk - FS_K) / FT);
   endfunction

   function automatic logic [7:0] rc();
      logic [7:0] c;
      c = 8'($urandom_range(0, 255));
      return (c == MASK) ? 8'hFF : c;
   endfunction

   // Layer controllers: registered answer to the coordinates requested this cycle
   always @(posedge clk)
      for (int l = 0; l < 4; l++)
         lc[l] <= lay(l, int'(ifc.requested_x), int'(ifc.requested_y), fr(k));

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(posedge clk);
      #1;
      if (resetN) k++;
   endtask

   task automatic run_to(int target);
      while (k < target) step();
   endtask

   task automatic restart();
      resetN = 1'b0;
      k = 0;
      @(posedge clk);
      @(posedge clk);
      #1;
      resetN = 1'b1;
      k = 0;
   endtask

   task automatic clear_scene();
      for (int l = 0; l < 4; l++)
         for (int y = 0; y < VT; y++)
            for (int x = 0; x < HT; x++) scene[l][y][x] = MASK;
      one_shot = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      resetN = 1'b0;
      k = 0;
      repeat (3) @(posedge clk);
      #1;
      n_chk++; if (ifc.requested_x !== 11'd0) begin n_fail++; $display("FAIL reset_x got %0d want 0", ifc.requested_x); end
      n_chk++; if (ifc.requested_y !== 11'd0) begin n_fail++; $display("FAIL reset_y got %0d want 0", ifc.requested_y); end
      n_chk++; if (ifc.hsync !== 1'b1) begin n_fail++; $display("FAIL reset_hsync got %b want 1", ifc.hsync); end
      n_chk++; if (ifc.vsync !== 1'b1) begin n_fail++; $display("FAIL reset_vsync got %b want 1", ifc.vsync); end
      n_chk++; if (ifc.blank !== 1'b1) begin n_fail++; $display("FAIL reset_blank got %b want 1", ifc.blank); end
      n_chk++; if (ifc.pixel_color !== 8'h00) begin n_fail++; $display("FAIL reset_pix got %h want 00", ifc.pixel_color); end
      n_chk++; if (ifc.frame_start !== 1'b0) begin n_fail++; $display("FAIL reset_fs got %b want 0", ifc.frame_start); end
      n_chk++; if (ifc.collisions !== 2'b00) begin n_fail++; $display("FAIL reset_coll got %b want 00", ifc.collisions); end
   endtask

   task automatic test_timing();
      int fs_cnt, hs_low, vs_low;
      clear_scene();
      for (int y = 0; y < VA; y++)
         for (int x = 0; x < HA; x++) scene[3][y][x] = rc();
      restart();
      fs_cnt = 0; hs_low = 0; vs_low = 0;
      for (int i = 0; i < FT + HT; i++) begin
         n_chk++; if (ifc.requested_x !== 11'(px(k)) || ifc.requested_y !== 11'(py(k))) begin
            n_fail++; $display("FAIL tim_req k=%0d got %0d,%0d want %0d,%0d", k, ifc.requested_x, ifc.requested_y, px(k), py(k)); end
         n_chk++; if (ifc.pixel_color !== exp_pix(k)) begin n_fail++; $display("FAIL tim_pix k=%0d got %h want %h", k, ifc.pixel_color, exp_pix(k)); end
         n_chk++; if (ifc.blank !== exp_blank(k)) begin n_fail++; $display("FAIL tim_blank k=%0d got %b want %b", k, ifc.blank, exp_blank(k)); end
         n_chk++; if (ifc.hsync !== exp_hs(k)) begin n_fail++; $display("FAIL tim_hsync k=%0d got %b want %b", k, ifc.hsync, exp_hs(k)); end
         n_chk++; if (ifc.vsync !== exp_vs(k)) begin n_fail++; $display("FAIL tim_vsync k=%0d got %b want %b", k, ifc.vsync, exp_vs(k)); end
         n_chk++; if (ifc.frame_start !== exp_fs(k)) begin n_fail++; $display("FAIL tim_fs k=%0d got %b want %b", k, ifc.frame_start, exp_fs(k)); end
         if (ifc.frame_start === 1'b1) fs_cnt++;
         if (k >= 2 && k < FT + 2) begin
            if (ifc.hsync === 1'b0) hs_low++;
            if (ifc.vsync === 1'b0) vs_low++;
         end
         step();
      end
      n_chk++; if (fs_cnt !== 1) begin n_fail++; $display("FAIL tim_fs_count got %0d want 1", fs_cnt); end
      n_chk++; if (hs_low !== (HSE - HSS) * VT) begin n_fail++; $display("FAIL tim_hs_low got %0d want %0d", hs_low, (HSE - HSS) * VT); end
      n_chk++; if (vs_low !== (VSE - VSS) * HT) begin n_fail++; $display("FAIL tim_vs_low got %0d want %0d", vs_low, (VSE - VSS) * HT); end
   endtask

   task automatic test_player();
      int t;
      clear_scene();
      scene[0][3][5] = 8'hE4;
      restart();
      t = 3 * HT + 5;
      run_to(t);
      n_chk++; if (ifc.requested_x !== 11'd5 || ifc.requested_y !== 11'd3) begin
         n_fail++; $display("FAIL ply_req got %0d,%0d want 5,3", ifc.requested_x, ifc.requested_y); end
      run_to(t + 2);
      n_chk++; if (ifc.pixel_color !== 8'hE4) begin n_fail++; $display("FAIL ply_pix got %h want e4", ifc.pixel_color); end
      n_chk++; if (ifc.blank !== 1'b0) begin n_fail++; $display("FAIL ply_blank got %b want 0", ifc.blank); end
      run_to(t + 3);
      n_chk++; if (ifc.pixel_color !== 8'h00) begin n_fail++; $display("FAIL ply_next_pix got %h want 00", ifc.pixel_color); end
      run_to(FS_K);
      n_chk++; if (ifc.frame_start !== 1'b1) begin n_fail++; $display("FAIL ply_fs got %b want 1", ifc.frame_start); end
      n_chk++; if (ifc.collisions !== 2'b00) begin n_fail++; $display("FAIL ply_coll got %b want 00", ifc.collisions); end
   endtask

   task automatic test_car_overlap();
      clear_scene();
      one_shot = 1'b1;
      scene[0][1][2] = 8'hE4;
      scene[1][1][2] = 8'hC0;
      restart();
      run_to(HT + 2 + 2);
      n_chk++; if (ifc.pixel_color !== 8'hE4) begin n_fail++; $display("FAIL car_pix got %h want e4", ifc.pixel_color); end
      run_to(FS_K);
      n_chk++; if (ifc.frame_start !== 1'b1) begin n_fail++; $display("FAIL car_fs got %b want 1", ifc.frame_start); end
      n_chk++; if (ifc.collisions !== 2'b10) begin n_fail++; $display("FAIL car_coll got %b want 10 (bit0 set)", ifc.collisions); end
      run_to(FS_K + FT);
      n_chk++; if (ifc.frame_start !== 1'b1) begin n_fail++; $display("FAIL car_fs2 got %b want 1", ifc.frame_start); end
      n_chk++; if (ifc.collisions !== 2'b00) begin n_fail++; $display("FAIL car_coll_clean got %b want 00", ifc.collisions); end
   endtask

   task automatic test_finish_corner();
      clear_scene();
      scene[0][VA-1][HA-1] = 8'hE4;
      scene[2][VA-1][HA-1] = 8'h1C;
      restart();
      run_to((VA - 1) * HT + HA - 1 + 2);
      n_chk++; if (ifc.pixel_color !== 8'hE4) begin n_fail++; $display("FAIL fin_pix got %h want e4", ifc.pixel_color); end
      n_chk++; if (ifc.blank !== 1'b0) begin n_fail++; $display("FAIL fin_blank got %b want 0", ifc.blank); end
      run_to(FS_K);
      n_chk++; if (ifc.collisions !== 2'b01) begin n_fail++; $display("FAIL fin_coll got %b want 01 (bit1 set)", ifc.collisions); end
   endtask

   task automatic test_outside();
      clear_scene();
      scene[0][2][HA+3] = 8'hE4;
      scene[1][2][HA+3] = 8'hC0;
      scene[2][2][HA+3] = 8'h1C;
      scene[3][2][HA+3] = 8'h03;
      restart();
      run_to(2 * HT + HA + 3 + 2);
      n_chk++; if (ifc.pixel_color !== 8'h00) begin n_fail++; $display("FAIL out_pix got %h want 00", ifc.pixel_color); end
      n_chk++; if (ifc.blank !== 1'b1) begin n_fail++; $display("FAIL out_blank got %b want 1", ifc.blank); end
      run_to(FS_K);
      n_chk++; if (ifc.collisions !== 2'b00) begin n_fail++; $display("FAIL out_coll got %b want 00", ifc.collisions); end
   endtask

   task automatic test_mid_reset();
      int early;
      clear_scene();
      scene[0][1][2] = 8'hE4;
      scene[1][1][2] = 8'hC0;
      restart();
      run_to(6 * HT + 7);
      #2 resetN = 1'b0;
      #1;
      n_chk++; if (ifc.requested_x !== 11'd0 || ifc.requested_y !== 11'd0) begin
         n_fail++; $display("FAIL mrst_req got %0d,%0d want 0,0", ifc.requested_x, ifc.requested_y); end
      n_chk++; if (ifc.pixel_color !== 8'h00) begin n_fail++; $display("FAIL mrst_pix got %h want 00", ifc.pixel_color); end
      n_chk++; if (ifc.blank !== 1'b1 || ifc.hsync !== 1'b1 || ifc.vsync !== 1'b1) begin
         n_fail++; $display("FAIL mrst_sync got blank=%b hs=%b vs=%b want 1,1,1", ifc.blank, ifc.hsync, ifc.vsync); end
      n_chk++; if (ifc.frame_start !== 1'b0 || ifc.collisions !== 2'b00) begin
         n_fail++; $display("FAIL mrst_fc got fs=%b coll=%b want 0,00", ifc.frame_start, ifc.collisions); end
      clear_scene();
      restart();
      early = 0;
      while (k < FS_K) begin
         if (ifc.frame_start === 1'b1) early++;
         step();
      end
      n_chk++; if (early !== 0) begin n_fail++; $display("FAIL mrst_early_fs got %0d want 0", early); end
      n_chk++; if (ifc.frame_start !== 1'b1) begin n_fail++; $display("FAIL mrst_fs got %b want 1", ifc.frame_start); end
      n_chk++; if (ifc.collisions !== 2'b00) begin n_fail++; $display("FAIL mrst_coll got %b want 00", ifc.collisions); end
   endtask

   task automatic test_random();
      int x, y, n;
      for (int it = 0; it < 3; it++) begin
         clear_scene();
         one_shot = (it == 2);
         for (int l = 0; l < 4; l++) begin
            n = $urandom_range(1, 8);
            for (int j = 0; j < n; j++) begin
               x = $urandom_range(0, HT - 1);
               y = $urandom_range(0, VT - 1);
               scene[l][y][x] = rc();
            end
         end
         x = $urandom_range(0, HA - 1);
         y = $urandom_range(0, VA - 1);
         scene[0][y][x] = rc();
         scene[(it % 2) + 1][y][x] = rc();
         restart();
         for (int i = 0; i < 2 * FT; i++) begin
            n_chk++; if (ifc.requested_x !== 11'(px(k)) || ifc.requested_y !== 11'(py(k))) begin
               n_fail++; $display("FAIL rnd_req k=%0d got %0d,%0d want %0d,%0d", k, ifc.requested_x, ifc.requested_y, px(k), py(k)); end
            n_chk++; if (ifc.pixel_color !== exp_pix(k)) begin n_fail++; $display("FAIL rnd_pix k=%0d got %h want %h", k, ifc.pixel_color, exp_pix(k)); end
            n_chk++; if (ifc.blank !== exp_blank(k)) begin n_fail++; $display("FAIL rnd_blank k=%0d got %b want %b", k, ifc.blank, exp_blank(k)); end
            n_chk++; if (ifc.hsync !== exp_hs(k) || ifc.vsync !== exp_vs(k)) begin
               n_fail++; $display("FAIL rnd_sync k=%0d got %b%b want %b%b", k, ifc.hsync, ifc.vsync, exp_hs(k), exp_vs(k)); end
            n_chk++; if (ifc.frame_start !== exp_fs(k)) begin n_fail++; $display("FAIL rnd_fs k=%0d got %b want %b", k, ifc.frame_start, exp_fs(k)); end
            n_chk++; if (ifc.collisions !== exp_coll(k)) begin n_fail++; $display("FAIL rnd_coll k=%0d got %b want %b", k, ifc.collisions, exp_coll(k)); end
            step();
         end
      end
   endtask

   initial begin
      n_chk = 0;
      n_fail = 0;
      k = 0;
      clear_scene();
      test_reset();
      test_timing();
      test_player();
      test_car_overlap();
      test_finish_corner();
      test_outside();
      test_mid_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
